// File: rtl/mips_fetch_unit.sv
// Instruction fetch stage: drives a registered-read instruction memory, tracks the
// single in-flight response, and hands words to decode through a one-entry skid buffer.
module mips_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter logic [31:0] NOP_WORD = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] prog_counter,
    input  logic [31:0] instruction,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        id_valid
);

    logic [31:0] pc_q, pc_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_pc_q, resp_pc_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic        id_valid_q, id_valid_d;
    logic        issue_en_s;

    // A full skid blocks issue, so at most one response is ever in flight when stall rises.
    assign issue_en_s = !stall && !skid_valid_q && !redirect;

    // Next-state logic for fetch, response tracking, skid buffer and decode outputs
    always_comb begin
        pc_d         = pc_q;
        resp_valid_d = 1'b0;
        resp_pc_d    = resp_pc_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        id_instr_d   = id_instr_q;
        id_pc_d      = id_pc_q;
        id_valid_d   = id_valid_q;

        if (redirect) begin
            // Flush everything; the response arriving this cycle is dropped.
            pc_d         = redirect_target;
            resp_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            id_valid_d   = 1'b0;
            id_instr_d   = NOP_WORD;
        end else begin
            if (issue_en_s) begin
                pc_d         = pc_q + 32'd1;
                resp_valid_d = 1'b1;
                resp_pc_d    = pc_q;
            end else begin
                pc_d         = pc_q;
                resp_valid_d = 1'b0;
            end

            if (!stall) begin
                if (skid_valid_q) begin
                    id_instr_d   = skid_instr_q;
                    id_pc_d      = skid_pc_q;
                    id_valid_d   = 1'b1;
                    skid_valid_d = 1'b0;
                end else if (resp_valid_q) begin
                    id_instr_d = instruction;
                    id_pc_d    = resp_pc_q;
                    id_valid_d = 1'b1;
                end else begin
                    id_instr_d = NOP_WORD;
                    id_valid_d = 1'b0;
                end
            end else begin
                if (resp_valid_q) begin
                    if (id_valid_q) begin
                        skid_instr_d = instruction;
                        skid_pc_d    = resp_pc_q;
                        skid_valid_d = 1'b1;
                    end else begin
                        id_instr_d = instruction;
                        id_pc_d    = resp_pc_q;
                        id_valid_d = 1'b1;
                    end
                end else begin
                    id_valid_d = id_valid_q;
                end
            end
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            resp_valid_q <= 1'b0;
            resp_pc_q    <= 32'h00000000;
            skid_valid_q <= 1'b0;
            skid_instr_q <= 32'h00000000;
            skid_pc_q    <= 32'h00000000;
            id_instr_q   <= NOP_WORD;
            id_pc_q      <= 32'h00000000;
            id_valid_q   <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            resp_valid_q <= resp_valid_d;
            resp_pc_q    <= resp_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            id_instr_q   <= id_instr_d;
            id_pc_q      <= id_pc_d;
            id_valid_q   <= id_valid_d;
        end
    end

    assign prog_counter = pc_q;
    assign id_instr     = id_instr_q;
    assign id_pc        = id_pc_q;
    assign id_valid     = id_valid_q;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit: streaming, stall/skid, redirect, PC wrap and
// asynchronous reset, against a registered-read memory holding word[n] = n + 100.
module tb_mips_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;

    logic [31:0] pc0, instr0, id_instr0, id_pc0;
    logic        id_valid0;
    logic [31:0] pc1, instr1, id_instr1, id_pc1;
    logic        id_valid1;

    int checks   = 0;
    int failures = 0;

    mips_fetch_unit dut0 (
        .clk(clk), .rst(rst), .prog_counter(pc0), .instruction(instr0),
        .stall(stall), .redirect(redirect), .redirect_target(redirect_target),
        .id_instr(id_instr0), .id_pc(id_pc0), .id_valid(id_valid0)
    );

    mips_fetch_unit #(.RESET_PC(32'hFFFFFFFE), .NOP_WORD(32'hFC000000)) dut1 (
        .clk(clk), .rst(rst), .prog_counter(pc1), .instruction(instr1),
        .stall(stall), .redirect(redirect), .redirect_target(redirect_target),
        .id_instr(id_instr1), .id_pc(id_pc1), .id_valid(id_valid1)
    );

    always #5 clk = ~clk;

    // Registered-read memory models
    always @(posedge clk) begin
        instr0 <= pc0 + 32'd100;
        instr1 <= pc1 + 32'd100;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic chk_id(input string tag, input logic v, input logic [31:0] p,
                          input logic [31:0] ins, input logic [31:0] pcv);
        chk({tag, ".id_valid"}, {31'd0, id_valid0}, {31'd0, v});
        chk({tag, ".id_pc"}, id_pc0, p);
        chk({tag, ".id_instr"}, id_instr0, ins);
        chk({tag, ".prog_counter"}, pc0, pcv);
    endtask

    task automatic chk_bubble(input string tag, input logic [31:0] pcv);
        chk({tag, ".id_valid"}, {31'd0, id_valid0}, 32'd0);
        chk({tag, ".id_instr"}, id_instr0, 32'd0);
        chk({tag, ".prog_counter"}, pc0, pcv);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 32'd0;
        #2;
        chk("rst.pc0", pc0, 32'd0);
        chk("rst.id_valid0", {31'd0, id_valid0}, 32'd0);
        chk("rst.id_instr0", id_instr0, 32'd0);
        chk("rst.id_pc0", id_pc0, 32'd0);
        chk("rst.pc1", pc1, 32'hFFFFFFFE);
        chk("rst.id_instr1", id_instr1, 32'hFC000000);
        @(negedge clk);
        rst = 1'b0;

        // Streaming from reset, plus PC wrap on the second instance
        step(); chk_bubble("e1", 32'd1);
        step(); chk_id("e2", 1'b1, 32'd0, 32'd100, 32'd2);
        chk("wrap.e2.id_pc", id_pc1, 32'hFFFFFFFE);
        chk("wrap.e2.id_instr", id_instr1, 32'h00000062);
        chk("wrap.e2.pc", pc1, 32'h00000000);
        step(); chk_id("e3", 1'b1, 32'd1, 32'd101, 32'd3);
        chk("wrap.e3.id_pc", id_pc1, 32'hFFFFFFFF);
        step(); chk_id("e4", 1'b1, 32'd2, 32'd102, 32'd4);
        chk("wrap.e4.id_pc", id_pc1, 32'h00000000);
        chk("wrap.e4.id_instr", id_instr1, 32'h00000064);
        for (int k = 5; k <= 7; k++) begin
            step(); chk_id($sformatf("e%0d", k), 1'b1, k - 2, k + 98, k);
        end

        // Stall three cycles at id_pc=5; word 6 goes to skid
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(); chk_id($sformatf("stall%0d", k), 1'b1, 32'd5, 32'd105, 32'd7);
        end
        stall = 1'b0;
        step(); chk_id("unskid", 1'b1, 32'd6, 32'd106, 32'd7);
        step(); chk_bubble("restart_bubble", 32'd8);
        step(); chk_id("restart", 1'b1, 32'd7, 32'd107, 32'd9);
        for (int k = 8; k <= 10; k++) begin
            step(); chk_id($sformatf("run%0d", k), 1'b1, k, k + 100, k + 2);
        end

        // Redirect to 0x40 while id_pc=10
        redirect = 1'b1; redirect_target = 32'h40;
        step(); chk_bubble("redir", 32'h40);
        redirect = 1'b0;
        step(); chk_bubble("redir+1", 32'h41);
        step(); chk_id("redir+2", 1'b1, 32'h40, 32'hA4, 32'h42);
        step(); chk_id("redir+3", 1'b1, 32'h41, 32'hA5, 32'h43);

        // Fill skid, then redirect with stall still high
        stall = 1'b1;
        step(); chk_id("skidfill", 1'b1, 32'h41, 32'hA5, 32'h43);
        redirect = 1'b1; redirect_target = 32'h80;
        step(); chk_bubble("redir_stall", 32'h80);
        redirect = 1'b0;
        step(); chk_bubble("redir_stall+1", 32'h80);
        stall = 1'b0;
        step(); chk_bubble("skid_cleared", 32'h81);
        step(); chk_id("redir_stall_tgt", 1'b1, 32'h80, 32'hE4, 32'h82);

        // Asynchronous reset with skid full
        stall = 1'b1;
        step(); chk_id("skidfill2", 1'b1, 32'h80, 32'hE4, 32'h82);
        #2 rst = 1'b1;
        #1;
        chk("arst.pc", pc0, 32'd0);
        chk("arst.id_valid", {31'd0, id_valid0}, 32'd0);
        chk("arst.id_instr", id_instr0, 32'd0);
        chk("arst.id_pc", id_pc0, 32'd0);
        @(negedge clk);
        rst = 1'b0; stall = 1'b0;
        step(); chk_bubble("rerun_e1", 32'd1);
        step(); chk_id("rerun_e2", 1'b1, 32'd0, 32'd100, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
